// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/PC stage of the 8-bit single-cycle CPU:
// FSM encoding, PC step constants and instruction field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INCREMENT = 4;
    localparam int unsigned OFFSET_SHIFT = 2;

    localparam int unsigned OFFSET_MSB   = 23;
    localparam int unsigned OFFSET_LSB   = 16;
    localparam int unsigned OFFSET_WIDTH = OFFSET_MSB - OFFSET_LSB + 1;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-PC logic: sequential PC, branch/jump target and the
// selected next PC. All arithmetic wraps modulo 2^PC_WIDTH.
module pc_target_adder
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0]     i_pc,
    input  logic [OFFSET_WIDTH-1:0] i_offset,
    input  logic                    i_branch,
    input  logic                    i_branch_ne,
    input  logic                    i_jump,
    input  logic                    i_zero,
    output logic [PC_WIDTH-1:0]     o_pc4,
    output logic [PC_WIDTH-1:0]     o_target,
    output logic [PC_WIDTH-1:0]     o_next_pc
);

    logic [PC_WIDTH-1:0] w_offset_words;
    logic                w_take;

    always_comb begin
        // Offset counts words, so sign-extend then scale to bytes
        w_offset_words = {{(PC_WIDTH - OFFSET_WIDTH){i_offset[OFFSET_WIDTH-1]}}, i_offset}
                         << OFFSET_SHIFT;
        o_pc4          = i_pc + PC_WIDTH'(PC_INCREMENT);
        o_target       = o_pc4 + w_offset_words;
        w_take         = i_jump | (i_branch & i_zero) | (i_branch_ne & ~i_zero);
        o_next_pc      = w_take ? o_target : o_pc4;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: IDLE -> FETCH -> EXEC loop with a
// busywait instruction-memory handshake and a data-memory stall held in EXEC.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         COUNT_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    BRANCH,
    input  logic                    BRANCH_NE,
    input  logic                    JUMP,
    input  logic                    ZERO,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    input  logic                    STALL,
    output logic                    IMEM_READ,
    output logic [PC_WIDTH-1:0]     IMEM_ADDRESS,
    input  logic [31:0]             IMEM_READDATA,
    input  logic                    IMEM_BUSYWAIT,
    output logic [31:0]             INSTRUCTION,
    output logic                    INSTR_VALID,
    output logic [PC_WIDTH-1:0]     PC,
    output logic [COUNT_WIDTH-1:0]  INSTR_COUNT
);

    fetch_state_e           r_state, w_state_next;
    logic [PC_WIDTH-1:0]    r_pc, w_pc_next;
    logic [31:0]            r_instr, w_instr_next;
    logic                   r_valid, w_valid_next;
    logic [COUNT_WIDTH-1:0] r_count, w_count_next;
    logic                   w_imem_read;

    logic [PC_WIDTH-1:0]    w_pc4, w_target, w_next_pc;

    pc_target_adder #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target_adder (
        .i_pc        (r_pc),
        .i_offset    (OFFSET),
        .i_branch    (BRANCH),
        .i_branch_ne (BRANCH_NE),
        .i_jump      (JUMP),
        .i_zero      (ZERO),
        .o_pc4       (w_pc4),
        .o_target    (w_target),
        .o_next_pc   (w_next_pc)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_valid_next = r_valid;
        w_count_next = r_count;
        w_imem_read  = 1'b0;
        case (r_state)
            IDLE: w_state_next = FETCH;
            FETCH: begin
                w_imem_read = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    w_instr_next = IMEM_READDATA;
                    w_valid_next = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                // Branch controls only matter on this committing edge
                if (!STALL) begin
                    w_pc_next    = w_next_pc;
                    w_count_next = r_count + COUNT_WIDTH'(1);
                    w_valid_next = 1'b0;
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
            r_count <= w_count_next;
        end
    end

    assign IMEM_READ    = w_imem_read;
    assign IMEM_ADDRESS = r_pc;
    assign INSTRUCTION  = r_instr;
    assign INSTR_VALID  = r_valid;
    assign PC           = r_pc;
    assign INSTR_COUNT  = r_count;

    a_next_pc_source: assert property (@(posedge CLK) disable iff (RESET)
        (w_next_pc == w_pc4) || (w_next_pc == w_target));
    a_pc_aligned: assert property (@(posedge CLK) disable iff (RESET)
        r_pc[1:0] == RESET_PC[1:0]);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// traffic checked against a phase-level reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, br, bne, jmp, zero, stall, busy;
    logic [7:0]  off;
    logic [31:0] rdata;

    logic        read0, valid0, read1, valid1;
    logic [31:0] addr0, instr0, pc0, addr1, instr1, pc1;
    logic [15:0] cnt0, cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 waiting for memory, 2 executing
    int          m_phase = 0;
    logic [31:0] m_pc0 = 32'h0;
    logic [31:0] m_pc1 = 32'hFFFF_FFFC;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt = 16'h0;

    pc_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .COUNT_WIDTH(16)) dut0 (
        .CLK(clk), .RESET(rst), .BRANCH(br), .BRANCH_NE(bne), .JUMP(jmp), .ZERO(zero),
        .OFFSET(off), .STALL(stall), .IMEM_READ(read0), .IMEM_ADDRESS(addr0),
        .IMEM_READDATA(rdata), .IMEM_BUSYWAIT(busy), .INSTRUCTION(instr0),
        .INSTR_VALID(valid0), .PC(pc0), .INSTR_COUNT(cnt0)
    );

    pc_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .COUNT_WIDTH(16)) dut1 (
        .CLK(clk), .RESET(rst), .BRANCH(br), .BRANCH_NE(bne), .JUMP(jmp), .ZERO(zero),
        .OFFSET(off), .STALL(stall), .IMEM_READ(read1), .IMEM_ADDRESS(addr1),
        .IMEM_READDATA(rdata), .IMEM_BUSYWAIT(busy), .INSTRUCTION(instr1),
        .INSTR_VALID(valid1), .PC(pc1), .INSTR_COUNT(cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic model_edge();
        int signed   o;
        bit          take;
        logic [31:0] step;
        if (rst) begin
            m_phase = 0;
            m_pc0   = 32'h0;
            m_pc1   = 32'hFFFF_FFFC;
            m_instr = 32'h0;
            m_cnt   = 16'h0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (!busy) begin
                m_instr = rdata;
                m_phase = 2;
            end
        end else if (!stall) begin
            o     = int'($signed(off));
            take  = jmp || (br && zero) || (bne && !zero);
            step  = take ? 32'(4 + 4 * o) : 32'd4;
            m_pc0 = m_pc0 + step;
            m_pc1 = m_pc1 + step;
            m_cnt = m_cnt + 16'd1;
            m_phase = 1;
        end
        m_valid = (m_phase == 2);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        br = 0; bne = 0; jmp = 0; zero = 0; off = 8'h00; stall = 0; busy = 0;
    endtask

    task automatic goto_exec_at(input logic [31:0] target);
        bit hit = 0;
        rst = 1; clear_ctrl(); tick(); rst = 0;
        for (int i = 0; i < 64 && !hit; i++) begin
            tick();
            hit = (m_phase == 2) && (m_pc0 == target);
        end
        n_cmp++;
        if (!hit || pc0 !== target || valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL goto_exec pc=%h valid=%b required pc=%h valid=1", pc0, valid0, target);
        end
    endtask

    task automatic test_reset();
        rst = 1; clear_ctrl(); rdata = 32'h0;
        tick(); tick();
        n_cmp++;
        if (pc0 !== 32'h0 || read0 !== 1'b0 || valid0 !== 1'b0 || cnt0 !== 16'h0
            || instr0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state pc=%h read=%b valid=%b cnt=%0d instr=%h required 0/0/0/0/0",
                     pc0, read0, valid0, cnt0, instr0);
        end
        n_cmp++;
        if (pc1 !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL reset_pc_param pc=%h required fffffffc", pc1);
        end
        rst = 0;
        n_cmp++;
        if (read0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_read read=%b required 0", read0);
        end
        tick();
        n_cmp++;
        if (read0 !== 1'b1 || addr0 !== 32'h0) begin
            n_fail++;
            $display("FAIL first_fetch read=%b addr=%h required 1/00000000", read0, addr0);
        end
    endtask

    task automatic test_sequential();
        clear_ctrl(); rdata = 32'h0001_0203;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (i % 2 == 0) begin
                if (valid0 !== 1'b1 || instr0 !== 32'h0001_0203 || pc0 !== 32'(i * 2)) begin
                    n_fail++;
                    $display("FAIL seq_exec[%0d] valid=%b instr=%h pc=%h required 1/00010203/%h",
                             i, valid0, instr0, pc0, 32'(i * 2));
                end
            end else if (valid0 !== 1'b0 || read0 !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d] valid=%b read=%b required 0/1", i, valid0, read0);
            end
        end
        n_cmp++;
        if (cnt0 !== 16'd3 || pc0 !== 32'd12) begin
            n_fail++;
            $display("FAIL seq_end cnt=%0d pc=%h required 3/0000000c", cnt0, pc0);
        end
    endtask

    task automatic test_branches();
        bit          t_br  [5] = '{1, 1, 0, 0, 1};
        bit          t_bne [5] = '{0, 0, 1, 0, 0};
        bit          t_jmp [5] = '{0, 0, 0, 1, 1};
        bit          t_z   [5] = '{1, 0, 0, 1, 0};
        logic [7:0]  t_off [5] = '{8'hFE, 8'hFE, 8'h03, 8'h7F, 8'h7F};
        logic [31:0] t_exp [5] = '{32'h0C, 32'h14, 32'h20, 32'h210, 32'h210};
        for (int k = 0; k < 5; k++) begin
            goto_exec_at(32'h10);
            br = t_br[k]; bne = t_bne[k]; jmp = t_jmp[k]; zero = t_z[k]; off = t_off[k];
            tick();
            clear_ctrl();
            n_cmp++;
            if (pc0 !== t_exp[k] || pc0 !== m_pc0 || pc1 !== m_pc1) begin
                n_fail++;
                $display("FAIL branch[%0d] pc=%h pc_alt=%h required %h/%h", k, pc0, pc1,
                         t_exp[k], m_pc1);
            end
        end
    endtask

    task automatic test_handshake();
        logic [31:0] word;
        goto_exec_at(32'h4);
        tick();
        busy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (read0 !== 1'b1 || addr0 !== 32'h8 || valid0 !== 1'b0) begin
                n_fail++;
                $display("FAIL busywait[%0d] read=%b addr=%h valid=%b required 1/00000008/0",
                         i, read0, addr0, valid0);
            end
        end
        word = $urandom; rdata = word; busy = 0;
        tick();
        n_cmp++;
        if (valid0 !== 1'b1 || instr0 !== word) begin
            n_fail++;
            $display("FAIL capture valid=%b instr=%h required 1/%h", valid0, instr0, word);
        end
        stall = 1; rdata = ~word;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (pc0 !== 32'h8 || instr0 !== word || cnt0 !== 16'd2 || valid0 !== 1'b1) begin
                n_fail++;
                $display("FAIL stall[%0d] pc=%h instr=%h cnt=%0d valid=%b required 8/%h/2/1",
                         i, pc0, instr0, cnt0, valid0, word);
            end
        end
        stall = 0;
        tick();
        n_cmp++;
        if (pc0 !== 32'hC || cnt0 !== 16'd3 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release pc=%h cnt=%0d valid=%b required c/3/0", pc0, cnt0, valid0);
        end
    endtask

    task automatic test_wrap();
        rst = 1; clear_ctrl(); tick(); rst = 0;
        tick(); tick();
        n_cmp++;
        if (pc1 !== 32'hFFFF_FFFC || valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_exec pc=%h valid=%b required fffffffc/1", pc1, valid1);
        end
        tick();
        n_cmp++;
        if (pc1 !== 32'h0 || addr1 !== 32'h0 || read1 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_next pc=%h addr=%h read=%b required 0/0/1", pc1, addr1, read1);
        end
    endtask

    task automatic test_reset_mid();
        goto_exec_at(32'h4);
        tick();
        busy = 1;
        tick();
        rst = 1; busy = 0; rdata = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if (read0 !== 1'b0 || pc0 !== 32'h0 || valid0 !== 1'b0 || cnt0 !== 16'h0
            || instr0 !== 32'h0 || pc1 !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL reset_mid read=%b pc=%h valid=%b cnt=%0d instr=%h required 0/0/0/0/0",
                     read0, pc0, valid0, cnt0, instr0);
        end
        rst = 0;
        tick();
        n_cmp++;
        if (read0 !== 1'b1 || addr0 !== 32'h0 || valid0 !== 1'b0 || instr0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_restart read=%b addr=%h valid=%b instr=%h required 1/0/0/0",
                     read0, addr0, valid0, instr0);
        end
    endtask

    task automatic test_random();
        rst = 1; clear_ctrl(); tick(); rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            busy  = ($urandom_range(0, 2) == 0);
            stall = ($urandom_range(0, 3) == 0);
            br    = $urandom_range(0, 1);
            bne   = $urandom_range(0, 1);
            jmp   = ($urandom_range(0, 3) == 0);
            zero  = $urandom_range(0, 1);
            off   = 8'($urandom);
            rdata = $urandom;
            tick();
            n_cmp++;
            if (pc0 !== m_pc0 || addr0 !== m_pc0 || pc1 !== m_pc1 || read0 !== (m_phase == 1)
                || valid0 !== m_valid || instr0 !== m_instr || cnt0 !== m_cnt) begin
                n_fail++;
                $display("FAIL random[%0d] pc=%h/%h read=%b valid=%b instr=%h cnt=%0d required %h/%h %b %b %h %0d",
                         i, pc0, pc1, read0, valid0, instr0, cnt0, m_pc0, m_pc1,
                         (m_phase == 1), m_valid, m_instr, m_cnt);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; clear_ctrl(); rdata = 32'h0;
        test_reset();
        test_sequential();
        test_branches();
        test_handshake();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch and program-counter stage of the 8-bit single-cycle CPU.
- Sits directly downstream of the 8-bit ALU: consumes its ZERO flag to resolve BEQ/BNE, plus the JUMP/BRANCH controls and 8-bit offset from the control unit.
- Fetches the next instruction word through a busywait-style instruction-memory handshake.
- Presents the instruction to decode for one or more EXEC cycles, and honours a data-memory stall.

Parameters:
- PC_WIDTH, 32, width of PC and instruction address.
- RESET_PC, 0, PC value loaded on reset.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BRANCH  in  1  BEQ in current instruction.
- BRANCH_NE  in  1  BNE in current instruction.
- JUMP  in  1  unconditional J in current instruction.
- ZERO  in  1  ALU zero flag for current instruction.
- OFFSET  in  8  signed word offset (instruction[23:16]).
- STALL  in  1  data-memory busywait; holds the current instruction in EXEC.
- IMEM_READ  out  1  instruction-memory read request.
- IMEM_ADDRESS  out  PC_WIDTH  fetch address (= PC).
- IMEM_READDATA  in  32  instruction word from memory.
- IMEM_BUSYWAIT  in  1  high while memory has not yet delivered the word.
- INSTRUCTION  out  32  registered instruction for decode.
- INSTR_VALID  out  1  high while INSTRUCTION is the live instruction.
- PC  out  PC_WIDTH  current program counter.
- INSTR_COUNT  out  COUNT_WIDTH  number of instructions retired.

Behaviour:
- Interface: one clock (CLK); reset (RESET) is synchronous and active-high. There is no asynchronous reset path.
- Reset (edge with RESET=1):
  - PC=RESET_PC, state=IDLE.
  - INSTRUCTION=0, INSTR_VALID=0, INSTR_COUNT=0.
  - IMEM_READ is 0 in IDLE.
  - RESET overrides every other input, including mid-FETCH or mid-STALL.
  - An abandoned memory read is simply dropped; any late word is ignored.
- FSM states IDLE, FETCH, EXEC:
  - IDLE: IMEM_READ=0. Next edge goes to FETCH unconditionally.
  - FETCH: IMEM_READ=1, IMEM_ADDRESS=PC, stable for the whole state.
    - Edge with IMEM_BUSYWAIT=1: stay in FETCH.
    - Edge with IMEM_BUSYWAIT=0: INSTRUCTION<=IMEM_READDATA, INSTR_VALID<=1, go to EXEC.
    - Minimum fetch latency is 1 cycle.
  - EXEC: IMEM_READ=0, INSTR_VALID=1.
    - Edge with STALL=1: hold PC, INSTRUCTION and INSTR_COUNT; stay in EXEC.
    - Edge with STALL=0: PC<=next_pc, INSTR_COUNT<=INSTR_COUNT+1, INSTR_VALID<=0, go to FETCH.
    - Branch inputs are sampled only on this committing edge.
- Throughput: 2 cycles per instruction with zero-wait memory and no stall.
- Next-PC rules:
  - pc4 = PC+4.
  - target = pc4 + (sign-extended OFFSET << 2).
  - All arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
  - take = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO).
  - next_pc = take ? target : pc4.
  - Simultaneous controls combine as a plain OR; no error is raised.
- Control inputs outside EXEC are don't-care.
- INSTR_COUNT wraps from all-ones to 0.
- PC is always word aligned; bits [1:0] never change from RESET_PC.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2).
  - PC_INCREMENT=4.
  - OFFSET_SHIFT=2.
  - Instruction field positions for the offset (23:16).
- One sub-module: pc_target_adder.
  - Combinational; computes pc4, target and next_pc from PC, OFFSET, BRANCH, BRANCH_NE, JUMP, ZERO.
  - Unit-testable on its own.

Test Plan:
- Reset and start-up: RESET=1 for 2 cycles, then 0.
  - During reset: PC=0, IMEM_READ=0, INSTR_VALID=0, INSTR_COUNT=0.
  - One IDLE cycle, then IMEM_READ=1 with IMEM_ADDRESS=0x00000000.
- Sequential, zero-wait memory: IMEM_BUSYWAIT=0 throughout, IMEM_READDATA=0x00010203, no branches.
  - INSTRUCTION=0x00010203 with INSTR_VALID=1 on alternate cycles.
  - PC sequence 0, 4, 8, 12.
  - INSTR_COUNT=3 after three commits.
- Branches at PC=0x10 (ZERO-dependent):
  - BRANCH=1, ZERO=1, OFFSET=0xFE -> PC=0x0C.
  - BRANCH=1, ZERO=0 -> PC=0x14.
  - BRANCH_NE=1, ZERO=0, OFFSET=0x03 -> PC=0x20.
- Jump with maximum positive offset: PC=0x10, JUMP=1, OFFSET=0x7F -> PC=0x210.
  - Same with ZERO=0 and BRANCH=1 also asserted -> PC=0x210.
- Handshake timing:
  - IMEM_BUSYWAIT=1 for 3 cycles: IMEM_READ stays 1, IMEM_ADDRESS stable, INSTR_VALID=0; instruction is captured on the first edge with busywait low.
  - STALL=1 for 2 EXEC cycles: PC, INSTRUCTION and INSTR_COUNT frozen; commit happens on the first edge with STALL=0.
- Wrap and reset mid-operation:
  - RESET_PC=0xFFFFFFFC, sequential run -> next PC=0x00000000.
  - RESET asserted while in FETCH with IMEM_BUSYWAIT=1 -> next cycle state=IDLE, IMEM_READ=0, PC=RESET_PC.
